// File: rtl/cla_seq_adder_pkg.sv
// Shared types and constants for the nibble-serial carry-lookahead adder.
// Holds the sequencer state encoding and the slice width.
package cla_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/cla_seq_adder_if.sv
// Operand/result handshake bundle for cla_seq_adder.
// Optional ovf signal is present only when CLA_SEQ_OVF_EN is defined.
interface cla_seq_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
`ifdef CLA_SEQ_OVF_EN
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy, ovf
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
`endif
endinterface

// File: rtl/cla_seq_adder_cla4_slice.sv
// Combinational 4-bit carry-lookahead adder slice.
// Exposes the carry into bit 3 so the caller can derive signed overflow.
module cla4_slice
    import cla_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a_i,
    input  logic [NIBBLE_W-1:0] b_i,
    input  logic                cin_i,
    output logic [NIBBLE_W-1:0] s_o,
    output logic                cout_o,
    output logic                c3_o
);
    logic [NIBBLE_W-1:0] g;
    logic [NIBBLE_W-1:0] p;
    logic                c1;
    logic                c2;
    logic                c3;
    logic                c4;

    // Lookahead carries expanded from generate/propagate terms.
    always_comb begin
        g  = a_i & b_i;
        p  = a_i ^ b_i;
        c1 = g[0] | (p[0] & cin_i);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & cin_i);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & cin_i);
        s_o    = p ^ {c3, c2, c1, cin_i};
        cout_o = c4;
        c3_o   = c3;
    end

endmodule

// File: rtl/cla_seq_adder.sv
// Nibble-serial adder: one shared 4-bit CLA slice, LSB nibble first.
// Define CLA_SEQ_OVF_EN to add the registered two's-complement ovf output.
module cla_seq_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    cla_seq_adder_if.slave  bus
);
    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

    if ((WIDTH < NIBBLE_W) || ((WIDTH % NIBBLE_W) != 0)) begin : g_bad_width
        $error("cla_seq_adder: WIDTH must be a multiple of 4 and >= 4");
    end

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
`ifdef CLA_SEQ_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    logic [NIBBLE_W-1:0] a_nib;
    logic [NIBBLE_W-1:0] b_nib;
    logic [NIBBLE_W-1:0] s_nib;
    logic                s_cout;
    logic                s_c3;

    // Select the operand nibbles addressed by the current index.
    always_comb begin
        a_nib = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
        b_nib = b_q[idx_q*NIBBLE_W +: NIBBLE_W];
    end

    cla4_slice u_slice (
        .a_i    (a_nib),
        .b_i    (b_nib),
        .cin_i  (carry_q),
        .s_o    (s_nib),
        .cout_o (s_cout),
        .c3_o   (s_c3)
    );

`ifndef CLA_SEQ_OVF_EN
    logic unused_c3;
    assign unused_c3 = s_c3;
`endif

    // Next-state and datapath update for the accept/run/drain sequence.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef CLA_SEQ_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.cin;
                    idx_d   = '0;
                    sum_d   = '0;
`ifdef CLA_SEQ_OVF_EN
                    ovf_d   = 1'b0;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q*NIBBLE_W +: NIBBLE_W] = s_nib;
                carry_d = s_cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    cout_d  = s_cout;
`ifdef CLA_SEQ_OVF_EN
                    ovf_d   = s_c3 ^ s_cout;
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef CLA_SEQ_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
`ifdef CLA_SEQ_OVF_EN
    assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_cla_seq_adder.sv
// Self-checking bench for cla_seq_adder (WIDTH=16).
// Optional ovf checks follow CLA_SEQ_OVF_EN.
module tb_cla_seq_adder;
    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;
    int   cyc;
    int   acc_q[$];

    cla_seq_adder_if #(.WIDTH(W)) bus();

    cla_seq_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at cycle %0d",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic logic mdl_ovf(input logic [W-1:0] a,
                                     input logic [W-1:0] b,
                                     input logic ci);
        logic [W-1:0] s;
        s = a + b + W'(ci);
        return (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    endfunction

    // Behavioural model: phase, remaining run cycles, expected result.
    typedef enum {M_IDLE, M_RUN, M_DONE} mph_e;
    mph_e         m_ph;
    int           m_left;
    logic [W-1:0] m_sum;
    logic         m_cout;
    logic         m_ovf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph   <= M_IDLE;
            m_left <= 0;
            m_sum  <= '0;
            m_cout <= 1'b0;
            m_ovf  <= 1'b0;
        end else begin
            case (m_ph)
                M_IDLE: if (bus.in_valid) begin
                    {m_cout, m_sum} <= {1'b0, bus.a} + {1'b0, bus.b}
                                       + (W+1)'(bus.cin);
                    m_ovf  <= mdl_ovf(bus.a, bus.b, bus.cin);
                    m_left <= NIB;
                    m_ph   <= M_RUN;
                end
                M_RUN: begin
                    m_left <= m_left - 1;
                    if (m_left == 1) m_ph <= M_DONE;
                end
                default: if (bus.out_ready) m_ph <= M_IDLE;
            endcase
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.in_valid && bus.in_ready) acc_q.push_back(cyc + 1);
            chk("in_ready", 32'(bus.in_ready), 32'(m_ph == M_IDLE));
            chk("out_valid", 32'(bus.out_valid), 32'(m_ph == M_DONE));
            chk("busy", 32'(bus.busy), 32'(m_ph != M_IDLE));
            if (m_ph == M_DONE) begin
                chk("m_sum", 32'(bus.sum), 32'(m_sum));
                chk("m_cout", 32'(bus.cout), 32'(m_cout));
`ifdef CLA_SEQ_OVF_EN
                chk("m_ovf", 32'(bus.ovf), 32'(m_ovf));
`endif
            end
        end
    end

    task automatic wait_ov(output int n);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.out_valid) chk("ov_timeout", 32'(bus.out_valid), 32'd1);
    endtask

    task automatic tx(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic ci, input logic [W-1:0] es,
                      input logic ec, input logic eo);
        int n;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = ci;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("busy_run", 32'(bus.busy), 32'd1);
        wait_ov(n);
        chk("latency", 32'(n), 32'(NIB));
        chk("sum", 32'(bus.sum), 32'(es));
        chk("cout", 32'(bus.cout), 32'(ec));
`ifdef CLA_SEQ_OVF_EN
        chk("ovf", 32'(bus.ovf), 32'(eo));
`else
        if (eo === 1'bx) chk("ovf_arg", 32'(eo), 32'd0);
`endif
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
        chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        int n;
        int seen;
        n_chk  = 0;
        n_fail = 0;
        cyc    = 0;
        rst_n  = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_sum", 32'(bus.sum), 32'd0);
        chk("rst_cout", 32'(bus.cout), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        tx(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        release_out();
        tx(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        release_out();
        tx(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        release_out();
        tx(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        release_out();

        // Hold DONE while offering a new pair that must be ignored.
        tx(16'h0F0F, 16'h0101, 1'b1, 16'h1011, 1'b0, 1'b0);
        bus.a        = 16'hDEAD;
        bus.b        = 16'hBEEF;
        bus.cin      = 1'b1;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("hold_sum", 32'(bus.sum), 32'h1011);
            chk("hold_cout", 32'(bus.cout), 32'd0);
            chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
            chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
        end
        bus.in_valid = 1'b0;
        release_out();

        // Asynchronous reset at nibble index 2.
        bus.a        = 16'h1111;
        bus.b        = 16'h2222;
        bus.cin      = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_sum", 32'(bus.sum), 32'd0);
        chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen++;
        end
        chk("arst_no_result", 32'(seen), 32'd0);

        // Back-to-back with both handshakes held high.
        acc_q.delete();
        bus.a         = 16'h000F;
        bus.b         = 16'h0001;
        bus.cin       = 1'b1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        wait_ov(n);
        chk("b2b_sum0", 32'(bus.sum), 32'h0011);
        chk("b2b_cout0", 32'(bus.cout), 32'd0);
        bus.a = 16'hAAAA;
        bus.b = 16'h5555;
        @(posedge clk);
        #1;
        wait_ov(n);
        chk("b2b_sum1", 32'(bus.sum), 32'h0000);
        chk("b2b_cout1", 32'(bus.cout), 32'd1);
        bus.in_valid  = 1'b0;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("b2b_accepts", 32'(acc_q.size()), 32'd2);
        if (acc_q.size() >= 2)
            chk("b2b_spacing", 32'(acc_q[1] - acc_q[0]), 32'd6);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
